// File: rtl/loader_pkg.sv
// -----------------------------------------------------------------------------
// loader_pkg -- shared definitions for the instruction-memory loader.
//
// Contents:
//   BYTES_PER_WORD : number of program bytes packed into one memory word (4)
//   state_t        : loader FSM state encoding
//   checksum_term  : value the trailing checksum byte must carry
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   Defined   -> the CHECK state exists and a trailing checksum byte is verified.
//   Undefined -> no CHECK state; the loader goes straight from the last write
//                to DONE.
// -----------------------------------------------------------------------------
package loader_pkg;

  localparam int BYTES_PER_WORD = 4;

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    WRITE,
    CHECK,
    DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    WRITE,
    DONE
  } state_t;
`endif

  // The trailing byte is correct when it brings the modulo-256 sum of the
  // whole image back to zero, i.e. it is the two's complement of the sum.
  function automatic logic [7:0] checksum_term(input logic [7:0] sum);
    return 8'(~sum + 8'd1);
  endfunction

endpackage

// File: rtl/instr_mem_loader_if.sv
// -----------------------------------------------------------------------------
// instr_mem_loader_if -- byte-stream handshake into the loader.
//
// Signals:
//   byte_in    : incoming program byte (source -> loader)
//   byte_valid : byte_in carries a byte (source -> loader)
//   byte_ready : loader takes the byte this cycle (loader -> source)
// A byte moves only on a cycle where byte_valid and byte_ready are both 1.
//
// Modports:
//   master : the byte source (testbench, UART front end, ...)
//   slave  : the loader
// -----------------------------------------------------------------------------
interface instr_mem_loader_if;

  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;

  modport master (
    output byte_in,
    output byte_valid,
    input  byte_ready
  );

  modport slave (
    input  byte_in,
    input  byte_valid,
    output byte_ready
  );

endinterface

// File: rtl/word_assembler.sv
// -----------------------------------------------------------------------------
// word_assembler -- packs accepted bytes into 32-bit little-endian words.
//
// Ports:
//   clk        : clock, rising edge
//   reset      : synchronous active-high reset
//   clear      : synchronous clear of byte counter and assembly register
//   accept     : a byte is transferred this cycle
//   byte_in    : the byte being transferred
//   word_out   : assembly register with the current byte merged in; complete
//                on the cycle word_valid is high
//   word_valid : 1-cycle pulse on the cycle the last byte of a word is accepted
//
// The k-th accepted byte of a word lands in bits [8k+7:8k].
// -----------------------------------------------------------------------------
module word_assembler
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_out,
  output logic        word_valid
);

  localparam int CNT_W = $clog2(BYTES_PER_WORD);

  logic [CNT_W-1:0] count_q;
  logic [31:0]      asm_q;
  logic [31:0]      asm_next;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    asm_next                        = asm_q;
    asm_next[{count_q, 3'b000} +: 8] = byte_in;
  end

  // Presenting the merged word combinationally lets the parent capture the
  // finished word on the same edge that accepts its last byte.
  assign word_out   = asm_next;
  assign word_valid = accept && (count_q == CNT_W'(BYTES_PER_WORD - 1));

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_q <= '0;
      asm_q   <= '0;
    end else if (accept) begin
      count_q <= count_q + CNT_W'(1);
      asm_q   <= asm_next;
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// -----------------------------------------------------------------------------
// instr_mem_loader -- streams a program image byte-by-byte into an instruction
// memory while holding the CPU core.
//
// Parameters:
//   ADDR_W   : byte-address width of the instruction memory; the image is
//              2**ADDR_W bytes = 2**(ADDR_W-2) words
//
// Ports:
//   clk      : clock, rising edge
//   reset    : synchronous active-high reset; priority over everything else
//   start    : begin a load (honoured only in IDLE or DONE)
//   bus      : byte-stream handshake (instr_mem_loader_if.slave)
//   mem_add  : byte address to the memory Add input (word_index*4)
//   mem_data : word to the memory InA input
//   mem_wen  : memory write enable, one cycle per word
//   cpu_hold : holds the CPU core while a load is in progress
//   done     : image fully written
//   err      : trailing checksum byte did not match
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   Defined   -> keep a modulo-256 sum of the image, accept one trailing byte
//                in CHECK and flag err when it is not the two's complement of
//                the sum.
//   Undefined -> no CHECK state, no sum logic, err tied to 0.
// -----------------------------------------------------------------------------
module instr_mem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  instr_mem_loader_if.slave   bus,
  output logic [31:0]         mem_add,
  output logic [31:0]         mem_data,
  output logic                mem_wen,
  output logic                cpu_hold,
  output logic                done,
  output logic                err
);

  localparam int IDX_W = ADDR_W - 2;
  localparam int DEPTH = 2 ** IDX_W;

  state_t           state_q;
  state_t           state_next;
  logic [IDX_W-1:0] word_idx_q;
  logic [31:0]      mem_add_q;
  logic [31:0]      mem_data_q;

  logic             start_load;
  logic             transfer;
  logic             collect_accept;
  logic             last_word;
  logic [31:0]      word_out;
  logic             word_valid;

  assign start_load     = start && (state_q == IDLE || state_q == DONE);
  assign transfer       = bus.byte_valid && bus.byte_ready;
  assign collect_accept = transfer && (state_q == COLLECT);
  // The index is saturated here rather than wrapped, so the final word never
  // rolls over onto address 0.
  assign last_word      = (word_idx_q == IDX_W'(DEPTH - 1));

  word_assembler u_word_assembler (
    .clk        (clk),
    .reset      (reset),
    .clear      (start_load),
    .accept     (collect_accept),
    .byte_in    (bus.byte_in),
    .word_out   (word_out),
    .word_valid (word_valid)
  );

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_next;
  end

  always_comb begin
    state_next = state_q;
    case (state_q)
      IDLE:    if (start) state_next = COLLECT;
      COLLECT: if (word_valid) state_next = WRITE;
      WRITE: begin
        if (!last_word) begin
          state_next = COLLECT;
        end else begin
`ifdef LOADER_CHECKSUM_EN
          state_next = CHECK;
`else
          state_next = DONE;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK:   if (transfer) state_next = DONE;
`endif
      DONE:    if (start) state_next = COLLECT;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Word index and memory bus registers
  // ---------------------------------------------------------------------------
  // NOTE: mem_add/mem_data are reset even though they are plain data
  // registers, because the memory port must read all-zero out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_idx_q <= '0;
      mem_add_q  <= '0;
      mem_data_q <= '0;
    end else begin
      if (start_load) begin
        word_idx_q <= '0;
      end else if (state_q == WRITE && !last_word) begin
        word_idx_q <= word_idx_q + IDX_W'(1);
      end
      // Captured on the edge that takes the last byte, then held until the
      // next word completes.
      if (word_valid) begin
        mem_add_q  <= 32'({word_idx_q, 2'b00});
        mem_data_q <= word_out;
      end
    end
  end

  assign mem_add  = mem_add_q;
  assign mem_data = mem_data_q;
  assign mem_wen  = (state_q == WRITE);
  assign done     = (state_q == DONE);

`ifdef LOADER_CHECKSUM_EN
  assign bus.byte_ready = (state_q == COLLECT) || (state_q == CHECK);
  assign cpu_hold       = (state_q == COLLECT) || (state_q == WRITE) ||
                          (state_q == CHECK);

  // ---------------------------------------------------------------------------
  // Checksum
  // ---------------------------------------------------------------------------
  logic [7:0] sum_q;
  logic       err_q;

  always_ff @(posedge clk) begin
    if (reset || start_load) begin
      sum_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (collect_accept) sum_q <= sum_q + bus.byte_in;
      if (state_q == CHECK && transfer) err_q <= (bus.byte_in != checksum_term(sum_q));
    end
  end

  assign err = err_q;
`else
  assign bus.byte_ready = (state_q == COLLECT);
  assign cpu_hold       = (state_q == COLLECT) || (state_q == WRITE);
  assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_mem_loader -- self-checking bench for instr_mem_loader.
//
// A driver streams images through the byte handshake and feeds every accepted
// byte to a reference model, which pushes the expected memory writes (address,
// word, cycle) into a queue. A monitor pops that queue on every mem_wen.
// Honours LOADER_CHECKSUM_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_instr_mem_loader;

  localparam int ADDR_W = 6;
  localparam int DEPTH  = 2 ** (ADDR_W - 2);
  localparam int NBYTES = DEPTH * 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] mem_add;
  logic [31:0] mem_data;
  logic        mem_wen;
  logic        cpu_hold;
  logic        done;
  logic        err;

  instr_mem_loader_if bus ();

  instr_mem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .bus      (bus),
    .mem_add  (mem_add),
    .mem_data (mem_data),
    .mem_wen  (mem_wen),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    longint      at;
  } wr_t;

  wr_t exp_q[$];
  int  writes = 0;

  // Reference model state: bytes of the current load, in acceptance order.
  int          m_k;
  int          m_widx;
  logic [31:0] m_word;
  logic [31:0] m_last;
  logic [7:0]  m_sum;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (mem_wen !== 1'b0) begin
      wr_t e;
      writes++;
      check("wr_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("wr_addr", 64'(mem_add), 64'(e.addr));
        check("wr_data", 64'(mem_data), 64'(e.data));
        check("wr_cycle", 64'(cyc), 64'(e.at));
        check("wr_byte_ready", 64'(bus.byte_ready), 64'd0);
        check("wr_cpu_hold", 64'(cpu_hold), 64'd1);
        check("wr_done", 64'(done), 64'd0);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model: little-endian packing, word index from 0, one write per
  // four accepted bytes, visible the cycle after the fourth byte's edge.
  // ---------------------------------------------------------------------------
  task automatic model_clear();
    m_k    = 0;
    m_widx = 0;
    m_word = 32'h0;
    m_sum  = 8'h0;
  endtask

  task automatic model_accept(input logic [7:0] b);
    m_word = m_word | (32'(b) << (8 * m_k));
    m_sum  = m_sum + b;
    m_k++;
    if (m_k == 4) begin
      exp_q.push_back('{addr: 32'(m_widx * 4), data: m_word, at: cyc + 1});
      m_last = m_word;
      m_widx++;
      m_k    = 0;
      m_word = 32'h0;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver (always entered and left on a falling edge)
  // ---------------------------------------------------------------------------
  task automatic send_byte(input logic [7:0] b, input bit trailer, input bit mid_start);
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    start          = mid_start;
    for (int t = 0; t < 8; t++) begin
      if (bus.byte_ready === 1'b1) begin
        if (!trailer) model_accept(b);
        @(negedge clk);
        start          = 1'b0;
        bus.byte_valid = 1'b0;
        return;
      end
      @(negedge clk);
      start = 1'b0;
    end
    check("byte_ready_timeout", 64'(bus.byte_ready), 64'd1);
    bus.byte_valid = 1'b0;
  endtask

  task automatic begin_load();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    model_clear();
    check("start_cpu_hold", 64'(cpu_hold), 64'd1);
    check("start_done", 64'(done), 64'd0);
    check("start_err", 64'(err), 64'd0);
    check("start_byte_ready", 64'(bus.byte_ready), 64'd1);
  endtask

  task automatic wait_done(input logic exp_err);
    for (int t = 0; t < 10; t++) begin
      if (done === 1'b1) break;
      @(negedge clk);
    end
    check("done", 64'(done), 64'd1);
    check("done_cpu_hold", 64'(cpu_hold), 64'd0);
    check("done_byte_ready", 64'(bus.byte_ready), 64'd0);
    check("done_mem_wen", 64'(mem_wen), 64'd0);
    check("done_err", 64'(err), 64'(exp_err));
    check("done_mem_add_hold", 64'(mem_add), 64'((DEPTH - 1) * 4));
    check("done_mem_data_hold", 64'(mem_data), 64'(m_last));
  endtask

  // fill: 0 random, 1 all 0x01, 2 directed 78 56 34 12 head then random
  // tr_delta: offset added to the correct trailing checksum byte
  task automatic run_load(input int fill, input int gap_max, input bit mid_start,
                          input logic [7:0] tr_delta);
    logic [7:0] img[NBYTES];
    logic [7:0] tr;
    logic       exp_err;
    int         w0;
    for (int i = 0; i < NBYTES; i++) begin
      if (fill == 1) img[i] = 8'h01;
      else           img[i] = 8'($urandom);
      if (fill == 2) begin
        case (i)
          0: img[i] = 8'h78;
          1: img[i] = 8'h56;
          2: img[i] = 8'h34;
          3: img[i] = 8'h12;
          default: ;
        endcase
      end
    end
    begin_load();
    w0 = writes;
    for (int i = 0; i < NBYTES; i++) begin
      int gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      bus.byte_valid = 1'b0;
      repeat (gap) @(negedge clk);
      send_byte(img[i], 1'b0, mid_start && (i > 0) && ($urandom_range(0, 3) == 0));
    end
    // Whole-image sum from the table, independent of the per-byte model.
    tr = 8'h0;
    for (int i = 0; i < NBYTES; i++) tr = tr - img[i];
    tr = tr + tr_delta;
`ifdef LOADER_CHECKSUM_EN
    send_byte(tr, 1'b1, 1'b0);
    exp_err = (tr_delta != 8'h0);
`else
    exp_err = 1'b0;
`endif
    wait_done(exp_err);
    check("write_count", 64'(writes - w0), 64'(DEPTH));
    check("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_byte_ready"}, 64'(bus.byte_ready), 64'd0);
    check({tag, "_mem_add"}, 64'(mem_add), 64'd0);
    check({tag, "_mem_data"}, 64'(mem_data), 64'd0);
    check({tag, "_mem_wen"}, 64'(mem_wen), 64'd0);
    check({tag, "_cpu_hold"}, 64'(cpu_hold), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_err"}, 64'(err), 64'd0);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    int w0;
    reset          = 1'b1;
    start          = 1'b0;
    bus.byte_in    = 8'h0;
    bus.byte_valid = 1'b0;
    model_clear();
    m_last = 32'h0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("idle");

    // Directed first word, continuous valid, full image.
    run_load(2, 0, 1'b0, 8'h00);
    // Restart from DONE with random gaps and stray start pulses mid-load.
    run_load(0, 3, 1'b1, 8'h00);
    // All-0x01 image: correct and off-by-one trailing byte.
    run_load(1, 0, 1'b0, 8'h00);
    run_load(1, 1, 1'b0, 8'h01);
    for (int n = 0; n < 3; n++) begin
      run_load(0, 2, 1'b1, ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255)));
    end

    // Reset after six bytes, together with start and a valid byte.
    begin_load();
    w0 = writes;
    for (int i = 0; i < 6; i++) send_byte(8'($urandom), 1'b0, 1'b0);
    reset          = 1'b1;
    start          = 1'b1;
    bus.byte_in    = 8'hA5;
    bus.byte_valid = 1'b1;
    @(negedge clk);
    reset          = 1'b0;
    start          = 1'b0;
    bus.byte_valid = 1'b0;
    check_all_zero("midload_reset");
    check("midload_write_count", 64'(writes - w0), 64'd1);
    check("midload_queue", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk);
    check("idle_hold_cpu_hold", 64'(cpu_hold), 64'd0);

    // Fresh load after reset starts again at address 0.
    run_load(0, 1, 1'b0, 8'h00);

    repeat (3) @(negedge clk);
    check("final_queue", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 6, meaning byte-address width of the target instruction memory (DEPTH = 2^ADDR_W/4 words).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port start, input, 1, request to begin a load.
REQ-005 SHALL have port byte_in, input, 8, incoming program byte.
REQ-006 SHALL have port byte_valid, input, 1, byte_in is valid.
REQ-007 SHALL have port byte_ready, output, 1, loader accepts a byte this cycle.
REQ-008 SHALL have port mem_add, output, 32, byte address to the instruction memory Add input.
REQ-009 SHALL have port mem_data, output, 32, word to the instruction memory InA input.
REQ-010 SHALL have port mem_wen, output, 1, write enable to the instruction memory WEN input.
REQ-011 SHALL have port cpu_hold, output, 1, holds the CPU core while loading.
REQ-012 SHALL have port done, output, 1, image fully written.
REQ-013 SHALL have port err, output, 1, checksum mismatch (see Configuration).

Function
REQ-014 SHALL implement FSM states IDLE, COLLECT, WRITE, CHECK, DONE.
REQ-015 SHALL transfer a byte only on a cycle where byte_valid and byte_ready are both 1.
REQ-016 SHALL, in IDLE or DONE with start=1, clear the word index, byte counter and assembly register, clear done and err, and enter COLLECT next cycle.
REQ-017 SHALL ignore start in COLLECT, WRITE and CHECK.
REQ-018 SHALL drive byte_ready=1 only in COLLECT and CHECK.
REQ-019 SHALL assemble little-endian: the k-th accepted byte of a word (k=0..3) goes to bits [8k+7:8k].
REQ-020 SHALL enter WRITE the cycle after the 4th byte is accepted.
REQ-021 SHALL, in WRITE, assert mem_wen for exactly one cycle with mem_add = word_index*4, zero-extended to 32 bits, and mem_data = the assembled word.
REQ-022 SHALL, after WRITE, enter COLLECT with word_index+1 if word_index < DEPTH-1. Otherwise it SHALL enter CHECK when LOADER_CHECKSUM_EN is defined, or DONE when it is not.
REQ-023 SHALL hold mem_wen=0 in every state other than WRITE. mem_add and mem_data SHALL hold their last values.
REQ-024 SHALL assert cpu_hold=1 in COLLECT, WRITE and CHECK, and 0 in IDLE and DONE.
REQ-025 SHALL assert done=1 in DONE only, and remain in DONE until start or reset.
REQ-026 SHALL tolerate arbitrary gaps in byte_valid; no timeout.
REQ-027 SHALL never let the word index exceed DEPTH-1, so no write ever aliases address 0.

Reset
REQ-028 SHALL, on reset=1 at a rising clk, enter IDLE regardless of state. All outputs SHALL be 0: byte_ready, mem_add, mem_data, mem_wen, cpu_hold, done, err.
REQ-029 SHALL NOT undo memory writes already issued when reset occurs mid-load; a partial image remains and done stays 0.
REQ-030 SHALL give reset priority over start and byte transfers in the same cycle.

Configuration
REQ-031 With LOADER_CHECKSUM_EN defined, the block SHALL keep an 8-bit modulo-256 sum of all image bytes.
REQ-032 With LOADER_CHECKSUM_EN defined, the block SHALL accept one further byte in CHECK, set err=1 if that byte does not equal the two's complement of the sum, and then enter DONE.
REQ-033 With LOADER_CHECKSUM_EN undefined, the block SHALL contain no CHECK state and no sum logic, SHALL tie err to 0, and SHALL go WRITE->DONE directly.

Structure
REQ-034 SHALL define the FSM state typedef and the byte-per-word constant (4) in shared package loader_pkg.
REQ-035 SHALL place byte counting and little-endian word assembly in sub-module word_assembler, with outputs word_out and word_valid (1-cycle pulse).

Verification
REQ-036 After reset, start pulse, then bytes 0x78,0x56,0x34,0x12 with continuous valid: mem_wen pulses once with mem_add=0x0, mem_data=0x12345678, one cycle after the 4th byte.
REQ-037 Full 64-byte image with ADDR_W=6: exactly 16 mem_wen pulses at addresses 0x00..0x3C step 4; done=1 and cpu_hold=0 afterward (no checksum build).
REQ-038 Reset asserted after 6 bytes: next cycle in IDLE, all outputs 0, a single write at 0x0 issued, done=0.
REQ-039 byte_valid held high during WRITE: byte_ready=0, so the 5th byte is accepted only in the following COLLECT cycle and no byte is lost or duplicated.
REQ-040 LOADER_CHECKSUM_EN build, 64 bytes all 0x01 (sum 0x40): trailing byte 0xC0 gives err=0 and done=1; trailing byte 0xC1 gives err=1 and done=1.
REQ-041 start pulsed mid-COLLECT: no effect; start in DONE: restarts at mem_add=0x0 with done cleared.
